// File: rtl/rv_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rv_bus_arbiter
//
// Shares one single-port RAM (1-cycle read latency) and one peripheral window
// between the instruction-fetch port and the data (load/store) port of a small
// RISC-V core. Only one RAM or peripheral access is in flight at a time;
// contention between fetch and data is resolved by strict alternation.
//
// Handshake: every request is a one-cycle enable pulse. Its address and data
// are captured into a pending register in that cycle; the matching response
// is a one-cycle valid pulse (instr_valid for fetches, data_valid for loads
// and stores). A second request of a type that is still pending is dropped.
// halt tells the core that at least one of its requests is still outstanding.
//
// Optional feature (macro ARB_PERIPH_TIMEOUT_EN): a peripheral access that has
// not been acknowledged within 255 cycles is terminated with data_valid and
// load data 32'hDEAD_BEEF. Without the macro the arbiter waits forever.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   instr_rd_en, pc    fetch request pulse and byte address
//   instr, instr_valid fetched word (held between pulses) and response pulse
//   mem_data_rd_en     load request pulse
//   mem_data_wr_en     store request pulse
//   mem_addr           data byte address
//   mem_write_data     store data
//   mem_wr_strb        store byte lanes
//   mem_read_data      load data (held between pulses)
//   data_valid         load/store completion pulse
//   halt               core stall while a request is outstanding
//   ram_*              single-port RAM interface (word addressed)
//   periph_*           peripheral request/acknowledge interface
//   dbg_state          current arbiter state, for observation only
// -----------------------------------------------------------------------------
module rv_bus_arbiter #(
  parameter int          ADDR_W      = 12,
  parameter logic [11:0] PERIPH_BASE = 12'h005
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              instr_rd_en,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  // data port
  input  logic              mem_data_rd_en,
  input  logic              mem_data_wr_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_write_data,
  input  logic [3:0]        mem_wr_strb,
  output logic [31:0]       mem_read_data,
  output logic              data_valid,
  output logic              halt,
  // RAM
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  // peripheral
  output logic              periph_req,
  output logic              periph_we,
  output logic [19:0]       periph_addr,
  output logic [31:0]       periph_wdata,
  output logic [3:0]        periph_strb,
  input  logic              periph_ack,
  input  logic [31:0]       periph_rdata,
  // observation
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DREAD  = 3'd2,
    S_DWRITE = 3'd3,
    S_PERIPH = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state;

  // pending request registers
  logic        fetch_pend;
  logic [31:0] fetch_addr;
  logic        data_pend;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_strb;

  logic        last_grant_data;  // 1: the most recent grant went to the data port
  logic        resp_fetch;       // which port the RESP state answers
  logic [31:0] instr_q;
  logic [31:0] rdata_q;

  // Effective request view for the IDLE grant: a pending request, or a
  // request arriving this very cycle (granted without waiting to be latched).
  logic        f_any;
  logic [31:0] f_addr;
  logic        d_req_in;
  logic        d_any;
  logic [31:0] d_addr;
  logic        d_wr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic        d_periph;
  logic        grant_data;

  logic        timeout;
  logic        periph_done;
  logic [31:0] periph_load;
  logic        unused_bits;

  assign f_any    = fetch_pend | instr_rd_en;
  assign f_addr   = fetch_pend ? fetch_addr : pc;
  assign d_req_in = mem_data_rd_en | mem_data_wr_en;
  assign d_any    = data_pend | d_req_in;
  assign d_addr   = data_pend ? data_addr  : mem_addr;
  assign d_wr     = data_pend ? data_wr    : mem_data_wr_en;
  assign d_wdata  = data_pend ? data_wdata : mem_write_data;
  assign d_strb   = data_pend ? data_strb  : mem_wr_strb;
  assign d_periph = (d_addr[31:20] == PERIPH_BASE);

  // Data wins ties unless it was served last; a lone request is served at once.
  assign grant_data = d_any && !(f_any && last_grant_data);

  // Fetch byte-offset bits and bits above the RAM window carry no meaning.
  assign unused_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0]};

`ifdef ARB_PERIPH_TIMEOUT_EN
  logic [7:0] to_cnt;
  // The counter equals the number of PERIPH cycles already spent without an
  // acknowledge; after 255 of them the current cycle ends the access.
  assign timeout = (state == S_PERIPH) && (to_cnt == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  assign periph_done = (state == S_PERIPH) && (periph_ack || timeout);
  assign periph_load = (timeout && !periph_ack) ? 32'hDEAD_BEEF : periph_rdata;

  // Response pulses are decoded from the state so they land in the same cycle
  // as the RAM read data / peripheral acknowledge they report.
  assign instr_valid = (state == S_RESP) && resp_fetch;
  assign data_valid  = ((state == S_RESP) && !resp_fetch) ||
                       (state == S_DWRITE) || periph_done;

  // Read data is forwarded in its valid cycle and held in a register afterwards.
  assign instr = instr_valid ? ram_rdata : instr_q;

  always_comb begin
    mem_read_data = rdata_q;
    if ((state == S_RESP) && !resp_fetch)
      mem_read_data = ram_rdata;
    else if (periph_done && !periph_we)
      mem_read_data = periph_load;
  end

  assign halt      = (fetch_pend && !instr_valid) || (data_pend && !data_valid);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      fetch_pend      <= 1'b0;
      fetch_addr      <= 32'h0;
      data_pend       <= 1'b0;
      data_wr         <= 1'b0;
      data_addr       <= 32'h0;
      data_wdata      <= 32'h0;
      data_strb       <= 4'h0;
      last_grant_data <= 1'b0;
      resp_fetch      <= 1'b0;
      instr_q         <= 32'h0;
      rdata_q         <= 32'h0;
      ram_en          <= 1'b0;
      ram_we          <= 4'h0;
      ram_addr        <= '0;
      ram_wdata       <= 32'h0;
      periph_req      <= 1'b0;
      periph_we       <= 1'b0;
      periph_addr     <= 20'h0;
      periph_wdata    <= 32'h0;
      periph_strb     <= 4'h0;
`ifdef ARB_PERIPH_TIMEOUT_EN
      to_cnt          <= 8'h0;
`endif
    end else begin
      // pending registers: cleared by their own response pulse, set by a
      // request pulse only when nothing of that type is outstanding
      if (instr_valid) begin
        fetch_pend <= 1'b0;
      end else if (instr_rd_en && !fetch_pend) begin
        fetch_pend <= 1'b1;
        fetch_addr <= pc;
      end

      if (data_valid) begin
        data_pend <= 1'b0;
      end else if (d_req_in && !data_pend) begin
        data_pend  <= 1'b1;
        data_wr    <= mem_data_wr_en;
        data_addr  <= mem_addr;
        data_wdata <= mem_write_data;
        data_strb  <= mem_wr_strb;
      end

      case (state)
        S_IDLE: begin
          if (grant_data) begin
            last_grant_data <= 1'b1;
            resp_fetch      <= 1'b0;
            if (d_periph) begin
              state        <= S_PERIPH;
              periph_req   <= 1'b1;
              periph_we    <= d_wr;
              periph_addr  <= d_addr[19:0];
              periph_wdata <= d_wdata;
              periph_strb  <= d_strb;
`ifdef ARB_PERIPH_TIMEOUT_EN
              to_cnt       <= 8'h0;
`endif
            end else if (d_wr) begin
              state     <= S_DWRITE;
              ram_en    <= 1'b1;
              ram_we    <= d_strb;
              ram_addr  <= d_addr[ADDR_W+1:2];
              ram_wdata <= d_wdata;
            end else begin
              state    <= S_DREAD;
              ram_en   <= 1'b1;
              ram_we   <= 4'h0;
              ram_addr <= d_addr[ADDR_W+1:2];
            end
          end else if (f_any) begin
            last_grant_data <= 1'b0;
            resp_fetch      <= 1'b1;
            state           <= S_FETCH;
            ram_en          <= 1'b1;
            ram_we          <= 4'h0;
            ram_addr        <= f_addr[ADDR_W+1:2];
          end
        end

        S_FETCH, S_DREAD: begin
          // the RAM samples the address this cycle and answers in RESP
          ram_en <= 1'b0;
          state  <= S_RESP;
        end

        S_RESP: begin
          if (resp_fetch) instr_q <= ram_rdata;
          else            rdata_q <= ram_rdata;
          state <= S_IDLE;
        end

        S_DWRITE: begin
          ram_en <= 1'b0;
          ram_we <= 4'h0;
          state  <= S_IDLE;
        end

        S_PERIPH: begin
          if (periph_done) begin
            periph_req <= 1'b0;
            if (!periph_we) rdata_q <= periph_load;
            state <= S_IDLE;
          end
`ifdef ARB_PERIPH_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv_bus_arbiter.md
RV_BUS_ARBITER -- requirements
Module: rv_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: RAM word-address width (4096 words).
REQ-002 Parameter PERIPH_BASE, default 12'h005: mem_addr[31:20] value selecting the peripheral window (UART at 32'h0050_0000).
REQ-003 Ports: clk  in  1  single clock, all logic on rising edge; rst_n  in  1  synchronous active-low reset.
REQ-004 Ports: instr_rd_en  in  1  fetch request pulse; pc  in  32  fetch byte address; instr  out  32  fetched word; instr_valid  out  1  fetch response pulse.
REQ-005 Ports: mem_data_rd_en  in  1  load request pulse; mem_data_wr_en  in  1  store request pulse; mem_addr  in  32  data byte address; mem_write_data  in  32  store data; mem_wr_strb  in  4  store byte lanes.
REQ-006 Ports: mem_read_data  out  32  load data; data_valid  out  1  load/store completion pulse; halt  out  1  core stall.
REQ-007 Ports: ram_en  out  1; ram_we  out  4; ram_addr  out  ADDR_W; ram_wdata  out  32; ram_rdata  in  32  (single-port RAM, 1-cycle read latency).
REQ-008 Ports: periph_req  out  1; periph_we  out  1; periph_addr  out  20; periph_wdata  out  32; periph_strb  out  4; periph_ack  in  1; periph_rdata  in  32.

Function
REQ-009 Request pulses, addresses and data are latched into fetch-pending / data-pending registers in the cycle the enable is high; a new request of a type already pending is ignored.
REQ-010 FSM states: IDLE, FETCH, DREAD, DWRITE, PERIPH, RESP; only one RAM or peripheral access in flight.
REQ-011 IDLE: with both pending, grant data unless last_grant==data, then fetch; a single pending type is granted immediately, including a request latched in the same cycle.
REQ-012 FETCH/DREAD: ram_en=1, ram_we=0, ram_addr=addr[ADDR_W+1:2] for one cycle, then RESP.
REQ-013 RESP: instr or mem_read_data = ram_rdata; instr_valid or data_valid =1 for exactly one cycle; pending cleared; next state IDLE (total latency request-to-valid = 2 cycles when uncontended).
REQ-014 DWRITE: ram_en=1, ram_we=mem_wr_strb latched, ram_wdata latched; data_valid=1 in that same cycle; next IDLE.
REQ-015 Data address with addr[31:20]==PERIPH_BASE goes to PERIPH instead of DREAD/DWRITE; RAM is not enabled.
REQ-016 PERIPH: periph_req held 1 with periph_addr=addr[19:0], periph_we, periph_wdata, periph_strb stable until the cycle periph_ack=1; on ack, loads capture periph_rdata into mem_read_data, data_valid=1 the same cycle, next IDLE.
REQ-017 Fetch addresses are never routed to the peripheral; bits above ADDR_W+1 are ignored for RAM.
REQ-018 halt=1 whenever any request is pending and its valid is not asserted in that cycle; halt=0 otherwise.
REQ-019 last_grant updates on every grant; strict alternation guarantees neither port waits more than one foreign access.
REQ-020 instr and mem_read_data hold their last value between valid pulses.

Reset
REQ-021 rst_n==0 at a rising edge: state=IDLE, pending flags cleared, last_grant=fetch, instr=0, mem_read_data=0, all valid/ram_en/ram_we/periph_req/halt=0.
REQ-022 Reset mid-access aborts it; no valid pulse is issued for the aborted request and periph_req drops the next cycle.

Configuration
REQ-023 Macro ARB_PERIPH_TIMEOUT_EN defined: an 8-bit counter runs in PERIPH; after 255 cycles without ack, the access ends, data_valid=1, load data=32'hDEAD_BEEF, state IDLE.
REQ-024 Macro undefined: no counter; PERIPH waits indefinitely for periph_ack.

Verification
REQ-025 Fetch pc=32'h0000_0010, ram_rdata=32'h0140_0193 -> ram_addr=4 in cycle 1, instr=32'h0140_0193 with instr_valid in cycle 2, halt=0 after.
REQ-026 Same-cycle fetch pc=0 and load mem_addr=32'h20 -> load served first (ram_addr=8), fetch next (ram_addr=0); halt=1 until instr_valid.
REQ-027 Store mem_addr=32'h0050_0000, data=32'h48, strb=4'b0001, ack after 3 cycles -> periph_req 3 cycles, periph_addr=0, ram_en=0, data_valid on ack cycle.
REQ-028 Reset asserted during PERIPH -> periph_req=0 next cycle, no data_valid, state IDLE.
REQ-029 With ARB_PERIPH_TIMEOUT_EN, load from 32'h0050_0004 with ack tied 0 -> data_valid after 255 cycles, mem_read_data=32'hDEAD_BEEF.
REQ-030 Continuous alternating load/fetch for 20 requests -> grants strictly alternate, each completes within 4 cycles of its request.
